// File: rtl/atm_session_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : atm_session_arbiter
// Brief    : Round-robin sharing of one ATM transaction core among card slots.
// Revision : 1.0
// =============================================================================
module atm_session_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ-1:0]      TIPO_TARJETA_IN,
    input  logic [4*N_REQ-1:0]    DIGITO_IN,
    input  logic [N_REQ-1:0]      DIGITO_STB_IN,
    input  logic [N_REQ-1:0]      TIPO_TRANS_IN,
    input  logic [32*N_REQ-1:0]   MONTO_IN,
    input  logic [N_REQ-1:0]      MONTO_STB_IN,
    output logic                  CORE_RESET_N,
    output logic                  CORE_TARJETA_RECIBIDA,
    output logic                  CORE_TIPO_DE_TARJETA,
    output logic [3:0]            CORE_DIGITO,
    output logic                  CORE_DIGITO_STB,
    output logic                  CORE_TIPO_TRANS,
    output logic [31:0]           CORE_MONTO,
    output logic                  CORE_MONTO_STB,
    input  logic                  CORE_BALANCE_ACTUALIZADO,
    input  logic                  CORE_ENTREGAR_DINERO,
    input  logic                  CORE_FONDOS_INSUFICIENTES,
    input  logic                  CORE_BLOQUEO,
    output logic [N_REQ-1:0]      GNT,
    output logic                  BUSY,
    output logic                  SESSION_TIMEOUT,
    output logic [N_REQ-1:0]      BLOQUEO_SLOT
);

    localparam int c_idx_w = $clog2(N_REQ);
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC);

    localparam logic [c_idx_w:0]   c_n_req    = (c_idx_w+1)'(N_REQ);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_REQ-1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT_CYC-1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_grant   = 2'd1;
    localparam logic [1:0] c_st_session = 2'd2;
    localparam logic [1:0] c_st_release = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [c_idx_w-1:0] r_gidx;
    logic [c_idx_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_monto_seen;
    logic [N_REQ-1:0]   r_bloqueo;

    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_rot;
    logic [c_idx_w:0]   w_sum;
    logic               w_found;
    logic [c_idx_w-1:0] w_pick_idx;
    logic [N_REQ-1:0]   w_pick_oh;
    logic               w_end;
    logic               w_fin;

    // Search rotated so bit 0 is the pointer slot; map the winner back with a wrap.
    always_comb begin
        w_elig     = REQ & ~r_bloqueo;
        w_rot      = N_REQ'({w_elig, w_elig} >> r_ptr);
        w_found    = 1'b0;
        w_sum      = '0;
        w_pick_oh  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (c_idx_w+1)'(i);
            end
        end
        w_pick_idx = c_idx_w'((w_sum >= c_n_req) ? (w_sum - c_n_req) : w_sum);
        if (w_found) begin
            w_pick_oh[w_pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state          = r_state;
        w_end                 = 1'b0;
        w_fin                 = 1'b0;
        CORE_RESET_N          = 1'b0;
        CORE_TARJETA_RECIBIDA = 1'b0;
        CORE_TIPO_DE_TARJETA  = 1'b0;
        CORE_DIGITO           = '0;
        CORE_DIGITO_STB       = 1'b0;
        CORE_TIPO_TRANS       = 1'b0;
        CORE_MONTO            = '0;
        CORE_MONTO_STB        = 1'b0;
        SESSION_TIMEOUT       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_next_state = c_st_grant;
                end
            end
            c_st_grant: begin
                CORE_RESET_N          = 1'b1;
                CORE_TARJETA_RECIBIDA = 1'b1;
                CORE_TIPO_DE_TARJETA  = TIPO_TARJETA_IN[r_gidx];
                w_next_state          = c_st_session;
            end
            c_st_session: begin
                CORE_RESET_N         = 1'b1;
                CORE_TIPO_DE_TARJETA = TIPO_TARJETA_IN[r_gidx];
                CORE_DIGITO          = DIGITO_IN[{r_gidx, 2'b00} +: 4];
                CORE_DIGITO_STB      = DIGITO_STB_IN[r_gidx];
                CORE_TIPO_TRANS      = TIPO_TRANS_IN[r_gidx];
                CORE_MONTO           = MONTO_IN[{r_gidx, 5'b00000} +: 32];
                CORE_MONTO_STB       = MONTO_STB_IN[r_gidx];
                // An early balance update is the other-bank fee, not a completed transaction.
                w_fin = CORE_ENTREGAR_DINERO | CORE_FONDOS_INSUFICIENTES |
                        (CORE_BALANCE_ACTUALIZADO & r_monto_seen);
                SESSION_TIMEOUT = (r_cnt == c_to_last) & ~CORE_BLOQUEO &
                                  REQ[r_gidx] & ~w_fin;
                w_end = CORE_BLOQUEO | ~REQ[r_gidx] | w_fin | SESSION_TIMEOUT;
                if (w_end) begin
                    w_next_state = c_st_release;
                end
            end
            c_st_release: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_gnt        <= '0;
            r_gidx       <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_monto_seen <= 1'b0;
            r_bloqueo    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_gnt  <= w_pick_oh;
                        r_gidx <= w_pick_idx;
                    end
                end
                c_st_grant: begin
                    r_cnt <= '0;
                end
                c_st_session: begin
                    if (w_end) begin
                        r_gnt <= '0;
                    end
                    if (CORE_BLOQUEO) begin
                        r_bloqueo[r_gidx] <= 1'b1;
                    end
                    if (CORE_DIGITO_STB || CORE_MONTO_STB) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (CORE_MONTO_STB) begin
                        r_monto_seen <= 1'b1;
                    end
                end
                c_st_release: begin
                    r_monto_seen <= 1'b0;
                    r_ptr        <= (r_gidx == c_last_idx) ? '0 : r_gidx + 1'b1;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign GNT          = r_gnt;
    assign BUSY         = (r_state != c_st_idle);
    assign BLOQUEO_SLOT = r_bloqueo;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_atm_session_arbiter
// Brief    : Randomized session-level stimulus with queue-based output scoreboard.
// Revision : 1.0
// =============================================================================
module tb_atm_session_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [N-1:0]    REQ, TIPO_TARJETA_IN, DIGITO_STB_IN, TIPO_TRANS_IN, MONTO_STB_IN;
    logic [4*N-1:0]  DIGITO_IN;
    logic [32*N-1:0] MONTO_IN;
    logic            CORE_BALANCE_ACTUALIZADO, CORE_ENTREGAR_DINERO;
    logic            CORE_FONDOS_INSUFICIENTES, CORE_BLOQUEO;
    logic            CORE_RESET_N, CORE_TARJETA_RECIBIDA, CORE_TIPO_DE_TARJETA;
    logic [3:0]      CORE_DIGITO;
    logic            CORE_DIGITO_STB, CORE_TIPO_TRANS, CORE_MONTO_STB;
    logic [31:0]     CORE_MONTO;
    logic [N-1:0]    GNT, BLOQUEO_SLOT;
    logic            BUSY, SESSION_TIMEOUT;

    always #5 CLK = ~CLK;

    atm_session_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ),
        .TIPO_TARJETA_IN(TIPO_TARJETA_IN), .DIGITO_IN(DIGITO_IN),
        .DIGITO_STB_IN(DIGITO_STB_IN), .TIPO_TRANS_IN(TIPO_TRANS_IN),
        .MONTO_IN(MONTO_IN), .MONTO_STB_IN(MONTO_STB_IN),
        .CORE_RESET_N(CORE_RESET_N), .CORE_TARJETA_RECIBIDA(CORE_TARJETA_RECIBIDA),
        .CORE_TIPO_DE_TARJETA(CORE_TIPO_DE_TARJETA), .CORE_DIGITO(CORE_DIGITO),
        .CORE_DIGITO_STB(CORE_DIGITO_STB), .CORE_TIPO_TRANS(CORE_TIPO_TRANS),
        .CORE_MONTO(CORE_MONTO), .CORE_MONTO_STB(CORE_MONTO_STB),
        .CORE_BALANCE_ACTUALIZADO(CORE_BALANCE_ACTUALIZADO),
        .CORE_ENTREGAR_DINERO(CORE_ENTREGAR_DINERO),
        .CORE_FONDOS_INSUFICIENTES(CORE_FONDOS_INSUFICIENTES),
        .CORE_BLOQUEO(CORE_BLOQUEO), .GNT(GNT), .BUSY(BUSY),
        .SESSION_TIMEOUT(SESSION_TIMEOUT), .BLOQUEO_SLOT(BLOQUEO_SLOT)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0]  q_gnt[$];   // {card type, one-hot grant}
    logic [3:0]  q_dig[$];
    logic [32:0] q_mon[$];   // {transaction type, amount}
    logic [3:0]  q_to[$];

    int           m_ptr;
    logic [N-1:0] m_blocked;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic miss(input string name);
        n_checks++;
        $display("FAIL %s: got an output, expected none (queue empty)", name);
    endtask

    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (elig[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Monitor: every core-facing event must match the next expectation in its queue.
    always @(negedge CLK) begin : mon
        logic [4:0]  eg;
        logic [3:0]  ed;
        logic [32:0] em;
        logic [3:0]  et;
        if (!RESET) begin
            if (CORE_TARJETA_RECIBIDA) begin
                if (q_gnt.size() == 0) miss("grant");
                else begin
                    eg = q_gnt.pop_front();
                    chk("gnt", GNT, eg[3:0]);
                    chk("tipo_tarjeta", CORE_TIPO_DE_TARJETA, eg[4]);
                    chk("core_reset_n_grant", CORE_RESET_N, 1);
                end
            end
            if (CORE_DIGITO_STB) begin
                if (q_dig.size() == 0) miss("digito_stb");
                else begin
                    ed = q_dig.pop_front();
                    chk("digito", CORE_DIGITO, ed);
                end
            end
            if (CORE_MONTO_STB) begin
                if (q_mon.size() == 0) miss("monto_stb");
                else begin
                    em = q_mon.pop_front();
                    chk("monto", CORE_MONTO, em[31:0]);
                    chk("tipo_trans", CORE_TIPO_TRANS, em[32]);
                end
            end
            if (SESSION_TIMEOUT) begin
                if (q_to.size() == 0) miss("session_timeout");
                else begin
                    et = q_to.pop_front();
                    chk("timeout_gnt", GNT, et);
                end
            end
        end
    end

    task automatic clear_inputs();
        DIGITO_STB_IN = '0; MONTO_STB_IN = '0;
        CORE_BALANCE_ACTUALIZADO = 0; CORE_ENTREGAR_DINERO = 0;
        CORE_FONDOS_INSUFICIENTES = 0; CORE_BLOQUEO = 0;
    endtask

    // kind: 0 dispense, 1 insufficient funds, 2 balance after amount, 3 timeout,
    //       4 card removed, 5 core block, 6 reset mid-session
    task automatic run_session(input logic [N-1:0] req, input int kind);
        int g, cnt, end_at;
        bit mseen, ended, bal;
        logic [N-1:0] cur_req, dstb, mstb, gbit;
        TIPO_TARJETA_IN = N'($urandom);
        TIPO_TRANS_IN   = N'($urandom);
        cur_req = req;
        REQ     = req;
        g = pick(req & ~m_blocked, m_ptr);
        if (g < 0) begin
            miss("no_eligible_slot");
            return;
        end
        gbit = N'(1) << g;
        q_gnt.push_back({TIPO_TARJETA_IN[g], gbit});
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        cnt = 0; mseen = 0; ended = 0;
        end_at = $urandom_range(2, 10);
        for (int k = 0; k < 40 && !ended; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            if (kind == 6 && k == end_at) begin
                clear_inputs();
                RESET = 1'b1; #1;
                chk("rst_mid_gnt", GNT, 0);
                chk("rst_mid_busy", BUSY, 0);
                chk("rst_mid_core_reset_n", CORE_RESET_N, 0);
                chk("rst_mid_bloqueo", BLOQUEO_SLOT, 0);
                chk("rst_mid_digito_stb", CORE_DIGITO_STB, 0);
                REQ = '0;
                @(negedge CLK); RESET = 1'b0;
                m_ptr = 0; m_blocked = '0;
                return;
            end
            DIGITO_IN = (4*N)'($urandom);
            MONTO_IN  = {$urandom, $urandom, $urandom, $urandom};
            dstb = N'($urandom) & ~gbit;
            mstb = N'($urandom) & N'($urandom) & ~gbit;
            if (kind != 3) begin
                if ($urandom_range(0, 99) < 40) dstb[g] = 1'b1;
                if ($urandom_range(0, 99) < 15 || (kind == 2 && k == 0)) mstb[g] = 1'b1;
            end
            cur_req = (N'($urandom) & ~gbit) | (cur_req & gbit);
            if (kind == 4 && k == end_at) cur_req[g] = 1'b0;
            bal = (kind == 2 && k == end_at) || (!mseen && $urandom_range(0, 99) < 10);
            REQ = cur_req;
            DIGITO_STB_IN = dstb;
            MONTO_STB_IN  = mstb;
            CORE_BALANCE_ACTUALIZADO  = bal;
            CORE_ENTREGAR_DINERO      = (kind == 0 && k == end_at);
            CORE_FONDOS_INSUFICIENTES = (kind == 1 && k == end_at);
            CORE_BLOQUEO              = (kind == 5 && k == end_at);
            if (dstb[g]) q_dig.push_back(DIGITO_IN[4*g +: 4]);
            if (mstb[g]) q_mon.push_back({TIPO_TRANS_IN[g], MONTO_IN[32*g +: 32]});
            if (CORE_BLOQUEO) begin
                ended = 1; m_blocked[g] = 1'b1;
            end else if (!cur_req[g]) ended = 1;
            else if (CORE_ENTREGAR_DINERO || CORE_FONDOS_INSUFICIENTES || (bal && mseen)) ended = 1;
            else if (cnt == TO - 1) begin
                ended = 1; q_to.push_back(gbit);
            end
            cnt   = (dstb[g] || mstb[g]) ? 0 : cnt + 1;
            mseen = mseen | mstb[g];
        end
        @(posedge CLK); #1;
        clear_inputs();
        @(negedge CLK);
        chk("release_gnt", GNT, 0);
        chk("release_core_reset_n", CORE_RESET_N, 0);
        chk("release_busy", BUSY, 1);
        chk("bloqueo_slot", BLOQUEO_SLOT, m_blocked);
        m_ptr = (g + 1) % N;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("idle_busy", BUSY, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        REQ = 4'b1111; TIPO_TARJETA_IN = '0; TIPO_TRANS_IN = '0;
        DIGITO_IN = '0; MONTO_IN = '0;
        clear_inputs();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_gnt", GNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_core_reset_n", CORE_RESET_N, 0);
        chk("rst_timeout", SESSION_TIMEOUT, 0);
        chk("rst_bloqueo", BLOQUEO_SLOT, 0);
        chk("rst_tarjeta", CORE_TARJETA_RECIBIDA, 0);
        chk("rst_strobes", {CORE_DIGITO_STB, CORE_MONTO_STB}, 0);
        chk("rst_data", {CORE_DIGITO, CORE_MONTO}, 0);
        REQ = '0;
        @(negedge CLK); RESET = 1'b0;
        m_ptr = 0; m_blocked = '0;
        @(posedge CLK); #1;
        chk("idle_no_req_busy", BUSY, 0);

        repeat (5) run_session(4'b1111, 0);
        run_session(4'b0001, 2);
        run_session(4'b0010, 3);
        run_session(4'b0001, 5);
        run_session(4'b0011, 0);
        run_session(4'b0011, 1);

        for (int s = 0; s < 40; s++) begin
            logic [N-1:0] r;
            int kd;
            r  = N'($urandom);
            if ((r & ~m_blocked) == '0) r = r | ~m_blocked;
            kd = $urandom_range(0, 5);
            if (kd == 5 && $countones(m_blocked) >= 2) kd = 0;
            run_session(r, kd);
        end

        run_session(4'b1111, 6);
        run_session(4'b0001, 0);

        chk("q_gnt_left", q_gnt.size(), 0);
        chk("q_dig_left", q_dig.size(), 0);
        chk("q_mon_left", q_mon.size(), 0);
        chk("q_to_left", q_to.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
